// File: rtl/alu_rs.sv
// alu_rs -- reservation station in front of the integer ALU.
//
// Buffers up to RS_SIZE decoded ALU/branch instructions, snoops the ALU and
// LSB common data buses for outstanding operands, and dispatches the
// lowest-index ready entry each cycle. The destination RoB tag is delayed one
// extra cycle so it lines up with the ALU's registered result.
//
// Ports:
//   clk_in, rst_in (async, active-high), rdy_in (global enable)
//   rob_clear                       synchronous flush of all entries
//   issue_*                         new instruction from the issue stage
//   alu_cdb_*, lsb_cdb_*            result broadcasts used for wakeup
//   rs_full                         every entry busy (combinational)
//   alu_waiting, alu_vj/vk/imm/op   registered dispatch to the ALU
//   result_rob_id                   tag paired with the ALU result
module alu_rs #(
    parameter int RS_WIDTH  = 3,
    parameter int ROB_WIDTH = 4
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 rob_clear,
    input  logic                 issue_valid,
    input  logic [5:0]           issue_op,
    input  logic [31:0]          issue_vj,
    input  logic                 issue_qj_busy,
    input  logic [ROB_WIDTH-1:0] issue_qj,
    input  logic [31:0]          issue_vk,
    input  logic                 issue_qk_busy,
    input  logic [ROB_WIDTH-1:0] issue_qk,
    input  logic [31:0]          issue_imm,
    input  logic [ROB_WIDTH-1:0] issue_rob_id,
    input  logic                 alu_cdb_valid,
    input  logic [ROB_WIDTH-1:0] alu_cdb_rob_id,
    input  logic [31:0]          alu_cdb_value,
    input  logic                 lsb_cdb_valid,
    input  logic [ROB_WIDTH-1:0] lsb_cdb_rob_id,
    input  logic [31:0]          lsb_cdb_value,
    output logic                 rs_full,
    output logic                 alu_waiting,
    output logic [31:0]          alu_vj,
    output logic [31:0]          alu_vk,
    output logic [31:0]          alu_imm,
    output logic [5:0]           alu_op,
    output logic [ROB_WIDTH-1:0] result_rob_id
);
    localparam int unsigned RS_SIZE = 1 << RS_WIDTH;

    // Entry storage
    logic [RS_SIZE-1:0]   busy_q, busy_d;
    logic [RS_SIZE-1:0]   qj_busy_q, qj_busy_d;
    logic [RS_SIZE-1:0]   qk_busy_q, qk_busy_d;
    logic [5:0]           op_q  [RS_SIZE];
    logic [5:0]           op_d  [RS_SIZE];
    logic [31:0]          vj_q  [RS_SIZE];
    logic [31:0]          vj_d  [RS_SIZE];
    logic [31:0]          vk_q  [RS_SIZE];
    logic [31:0]          vk_d  [RS_SIZE];
    logic [31:0]          imm_q [RS_SIZE];
    logic [31:0]          imm_d [RS_SIZE];
    logic [ROB_WIDTH-1:0] qj_q  [RS_SIZE];
    logic [ROB_WIDTH-1:0] qj_d  [RS_SIZE];
    logic [ROB_WIDTH-1:0] qk_q  [RS_SIZE];
    logic [ROB_WIDTH-1:0] qk_d  [RS_SIZE];
    logic [ROB_WIDTH-1:0] rob_q [RS_SIZE];
    logic [ROB_WIDTH-1:0] rob_d [RS_SIZE];

    // Dispatch / result pipeline
    logic                 waiting_q, waiting_d;
    logic [31:0]          out_vj_q, out_vj_d;
    logic [31:0]          out_vk_q, out_vk_d;
    logic [31:0]          out_imm_q, out_imm_d;
    logic [5:0]           out_op_q, out_op_d;
    logic [ROB_WIDTH-1:0] disp_rob_q, disp_rob_d;
    logic [ROB_WIDTH-1:0] result_q, result_d;

    logic [RS_SIZE-1:0]   ready;
    logic                 free_found, disp_found;
    logic [RS_WIDTH-1:0]  free_idx, disp_idx;

    assign rs_full       = &busy_q;
    assign ready         = busy_q & ~qj_busy_q & ~qk_busy_q;
    assign alu_waiting   = waiting_q;
    assign alu_vj        = out_vj_q;
    assign alu_vk        = out_vk_q;
    assign alu_imm       = out_imm_q;
    assign alu_op        = out_op_q;
    assign result_rob_id = result_q;

    // Lowest-index free slot and lowest-index ready slot
    always_comb begin : pick
        free_found = 1'b0;
        free_idx   = '0;
        disp_found = 1'b0;
        disp_idx   = '0;
        for (int unsigned i = 0; i < RS_SIZE; i++) begin
            if (!free_found && !busy_q[i]) begin
                free_found = 1'b1;
                free_idx   = RS_WIDTH'(i);
            end
            if (!disp_found && ready[i]) begin
                disp_found = 1'b1;
                disp_idx   = RS_WIDTH'(i);
            end
        end
    end

    always_comb begin : next_state
        busy_d     = busy_q;
        qj_busy_d  = qj_busy_q;
        qk_busy_d  = qk_busy_q;
        op_d       = op_q;
        vj_d       = vj_q;
        vk_d       = vk_q;
        imm_d      = imm_q;
        qj_d       = qj_q;
        qk_d       = qk_q;
        rob_d      = rob_q;
        waiting_d  = 1'b0;
        out_vj_d   = '0;
        out_vk_d   = '0;
        out_imm_d  = '0;
        out_op_d   = '0;
        disp_rob_d = '0;
        result_d   = disp_rob_q;

        if (rob_clear) begin
            // The instruction dispatched last cycle is squashed too, so its
            // tag must not surface on result_rob_id.
            busy_d   = '0;
            result_d = '0;
        end else begin
            // Wakeup; the ALU bus takes priority over the LSB bus
            for (int unsigned i = 0; i < RS_SIZE; i++) begin
                if (busy_q[i] && qj_busy_q[i]) begin
                    if (alu_cdb_valid && alu_cdb_rob_id == qj_q[i]) begin
                        vj_d[i]      = alu_cdb_value;
                        qj_busy_d[i] = 1'b0;
                    end else if (lsb_cdb_valid && lsb_cdb_rob_id == qj_q[i]) begin
                        vj_d[i]      = lsb_cdb_value;
                        qj_busy_d[i] = 1'b0;
                    end
                end
                if (busy_q[i] && qk_busy_q[i]) begin
                    if (alu_cdb_valid && alu_cdb_rob_id == qk_q[i]) begin
                        vk_d[i]      = alu_cdb_value;
                        qk_busy_d[i] = 1'b0;
                    end else if (lsb_cdb_valid && lsb_cdb_rob_id == qk_q[i]) begin
                        vk_d[i]      = lsb_cdb_value;
                        qk_busy_d[i] = 1'b0;
                    end
                end
            end

            if (disp_found) begin
                waiting_d        = 1'b1;
                out_vj_d         = vj_q[disp_idx];
                out_vk_d         = vk_q[disp_idx];
                out_imm_d        = imm_q[disp_idx];
                out_op_d         = op_q[disp_idx];
                disp_rob_d       = rob_q[disp_idx];
                busy_d[disp_idx] = 1'b0;
            end

            // rs_full reflects cycle-start occupancy, so a slot freed by this
            // cycle's dispatch is never the issue target.
            if (issue_valid && !rs_full && free_found) begin
                busy_d[free_idx]    = 1'b1;
                op_d[free_idx]      = issue_op;
                imm_d[free_idx]     = issue_imm;
                rob_d[free_idx]     = issue_rob_id;
                qj_d[free_idx]      = issue_qj;
                qk_d[free_idx]      = issue_qk;
                vj_d[free_idx]      = issue_vj;
                vk_d[free_idx]      = issue_vk;
                qj_busy_d[free_idx] = issue_qj_busy;
                qk_busy_d[free_idx] = issue_qk_busy;
                if (issue_qj_busy) begin
                    if (alu_cdb_valid && alu_cdb_rob_id == issue_qj) begin
                        vj_d[free_idx]      = alu_cdb_value;
                        qj_busy_d[free_idx] = 1'b0;
                    end else if (lsb_cdb_valid && lsb_cdb_rob_id == issue_qj) begin
                        vj_d[free_idx]      = lsb_cdb_value;
                        qj_busy_d[free_idx] = 1'b0;
                    end
                end
                if (issue_qk_busy) begin
                    if (alu_cdb_valid && alu_cdb_rob_id == issue_qk) begin
                        vk_d[free_idx]      = alu_cdb_value;
                        qk_busy_d[free_idx] = 1'b0;
                    end else if (lsb_cdb_valid && lsb_cdb_rob_id == issue_qk) begin
                        vk_d[free_idx]      = lsb_cdb_value;
                        qk_busy_d[free_idx] = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            busy_q     <= '0;
            qj_busy_q  <= '0;
            qk_busy_q  <= '0;
            for (int unsigned i = 0; i < RS_SIZE; i++) begin
                op_q[i]  <= '0;
                vj_q[i]  <= '0;
                vk_q[i]  <= '0;
                imm_q[i] <= '0;
                qj_q[i]  <= '0;
                qk_q[i]  <= '0;
                rob_q[i] <= '0;
            end
            waiting_q  <= 1'b0;
            out_vj_q   <= '0;
            out_vk_q   <= '0;
            out_imm_q  <= '0;
            out_op_q   <= '0;
            disp_rob_q <= '0;
            result_q   <= '0;
        end else if (rdy_in) begin
            busy_q     <= busy_d;
            qj_busy_q  <= qj_busy_d;
            qk_busy_q  <= qk_busy_d;
            op_q       <= op_d;
            vj_q       <= vj_d;
            vk_q       <= vk_d;
            imm_q      <= imm_d;
            qj_q       <= qj_d;
            qk_q       <= qk_d;
            rob_q      <= rob_d;
            waiting_q  <= waiting_d;
            out_vj_q   <= out_vj_d;
            out_vk_q   <= out_vk_d;
            out_imm_q  <= out_imm_d;
            out_op_q   <= out_op_d;
            disp_rob_q <= disp_rob_d;
            result_q   <= result_d;
        end
    end

endmodule

// File: tb/tb_alu_rs.sv
// Directed testbench for alu_rs: inputs are driven and outputs checked on the
// falling clock edge; the DUT updates on the rising edge.
module tb_alu_rs;
    localparam int RS_WIDTH  = 3;
    localparam int ROB_WIDTH = 4;

    logic                 clk_in = 1'b0;
    logic                 rst_in = 1'b1;
    logic                 rdy_in = 1'b1;
    logic                 rob_clear = 1'b0;
    logic                 issue_valid = 1'b0;
    logic [5:0]           issue_op = '0;
    logic [31:0]          issue_vj = '0;
    logic                 issue_qj_busy = 1'b0;
    logic [ROB_WIDTH-1:0] issue_qj = '0;
    logic [31:0]          issue_vk = '0;
    logic                 issue_qk_busy = 1'b0;
    logic [ROB_WIDTH-1:0] issue_qk = '0;
    logic [31:0]          issue_imm = '0;
    logic [ROB_WIDTH-1:0] issue_rob_id = '0;
    logic                 alu_cdb_valid = 1'b0;
    logic [ROB_WIDTH-1:0] alu_cdb_rob_id = '0;
    logic [31:0]          alu_cdb_value = '0;
    logic                 lsb_cdb_valid = 1'b0;
    logic [ROB_WIDTH-1:0] lsb_cdb_rob_id = '0;
    logic [31:0]          lsb_cdb_value = '0;
    logic                 rs_full;
    logic                 alu_waiting;
    logic [31:0]          alu_vj, alu_vk, alu_imm;
    logic [5:0]           alu_op;
    logic [ROB_WIDTH-1:0] result_rob_id;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_in = ~clk_in;

    alu_rs #(.RS_WIDTH(RS_WIDTH), .ROB_WIDTH(ROB_WIDTH)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .rob_clear(rob_clear),
        .issue_valid(issue_valid), .issue_op(issue_op),
        .issue_vj(issue_vj), .issue_qj_busy(issue_qj_busy), .issue_qj(issue_qj),
        .issue_vk(issue_vk), .issue_qk_busy(issue_qk_busy), .issue_qk(issue_qk),
        .issue_imm(issue_imm), .issue_rob_id(issue_rob_id),
        .alu_cdb_valid(alu_cdb_valid), .alu_cdb_rob_id(alu_cdb_rob_id), .alu_cdb_value(alu_cdb_value),
        .lsb_cdb_valid(lsb_cdb_valid), .lsb_cdb_rob_id(lsb_cdb_rob_id), .lsb_cdb_value(lsb_cdb_value),
        .rs_full(rs_full), .alu_waiting(alu_waiting), .alu_vj(alu_vj), .alu_vk(alu_vk),
        .alu_imm(alu_imm), .alu_op(alu_op), .result_rob_id(result_rob_id)
    );

    task automatic step();
        @(negedge clk_in);
    endtask

    task automatic idle();
        issue_valid   = 1'b0;
        alu_cdb_valid = 1'b0;
        lsb_cdb_valid = 1'b0;
        rob_clear     = 1'b0;
    endtask

    task automatic issue(input logic [5:0] op, input logic [31:0] vj, input logic qjb,
                         input logic [3:0] qj, input logic [31:0] vk, input logic qkb,
                         input logic [3:0] qk, input logic [31:0] imm, input logic [3:0] rob);
        issue_valid   = 1'b1;
        issue_op      = op;
        issue_vj      = vj;
        issue_qj_busy = qjb;
        issue_qj      = qj;
        issue_vk      = vk;
        issue_qk_busy = qkb;
        issue_qk      = qk;
        issue_imm     = imm;
        issue_rob_id  = rob;
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        idle();
        step();
        step();
        n_checks++; if (alu_waiting !== 1'b0) begin n_fail++; $display("FAIL reset_waiting: got %0h expected 0", alu_waiting); end
        n_checks++; if (rs_full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %0h expected 0", rs_full); end
        n_checks++; if (alu_vj !== 32'h0 || alu_vk !== 32'h0 || alu_imm !== 32'h0 || alu_op !== 6'h0)
            begin n_fail++; $display("FAIL reset_data: got vj=%0h vk=%0h imm=%0h op=%0h expected all 0", alu_vj, alu_vk, alu_imm, alu_op); end
        n_checks++; if (result_rob_id !== 4'h0) begin n_fail++; $display("FAIL reset_result: got %0h expected 0", result_rob_id); end
        rst_in = 1'b0;
        step();
    endtask

    task automatic test_basic();
        issue(6'b000011, 32'd5, 1'b0, 4'd0, 32'd7, 1'b0, 4'd0, 32'd0, 4'd2);
        step();
        idle();
        n_checks++; if (alu_waiting !== 1'b0) begin n_fail++; $display("FAIL basic_early: got %0h expected 0", alu_waiting); end
        step();
        n_checks++; if (alu_waiting !== 1'b1 || alu_vj !== 32'd5 || alu_vk !== 32'd7 || alu_op !== 6'b000011)
            begin n_fail++; $display("FAIL basic_dispatch: got w=%0h vj=%0h vk=%0h op=%0h expected w=1 vj=5 vk=7 op=3", alu_waiting, alu_vj, alu_vk, alu_op); end
        step();
        n_checks++; if (result_rob_id !== 4'd2) begin n_fail++; $display("FAIL basic_result: got %0h expected 2", result_rob_id); end
        n_checks++; if (alu_waiting !== 1'b0) begin n_fail++; $display("FAIL basic_after: got %0h expected 0", alu_waiting); end
        step();
    endtask

    task automatic test_wakeup();
        issue(6'd8, 32'd0, 1'b1, 4'd4, 32'd1, 1'b0, 4'd0, 32'd0, 4'd3);
        step();
        idle();
        n_checks++; if (alu_waiting !== 1'b0) begin n_fail++; $display("FAIL wake_wait1: got %0h expected 0", alu_waiting); end
        step();
        n_checks++; if (alu_waiting !== 1'b0) begin n_fail++; $display("FAIL wake_wait2: got %0h expected 0", alu_waiting); end
        alu_cdb_valid = 1'b1; alu_cdb_rob_id = 4'd4; alu_cdb_value = 32'h10;
        step();
        idle();
        n_checks++; if (alu_waiting !== 1'b0) begin n_fail++; $display("FAIL wake_bcast_edge: got %0h expected 0", alu_waiting); end
        step();
        n_checks++; if (alu_waiting !== 1'b1 || alu_vj !== 32'h10 || alu_vk !== 32'd1)
            begin n_fail++; $display("FAIL wake_dispatch: got w=%0h vj=%0h vk=%0h expected w=1 vj=10 vk=1", alu_waiting, alu_vj, alu_vk); end
        step();
        // Same-cycle forwarding: j from the ALU bus, k from the LSB bus
        issue(6'd9, 32'd0, 1'b1, 4'd5, 32'd0, 1'b1, 4'd6, 32'd0, 4'd7);
        alu_cdb_valid = 1'b1; alu_cdb_rob_id = 4'd5; alu_cdb_value = 32'h22;
        lsb_cdb_valid = 1'b1; lsb_cdb_rob_id = 4'd6; lsb_cdb_value = 32'h33;
        step();
        idle();
        n_checks++; if (alu_waiting !== 1'b0) begin n_fail++; $display("FAIL fwd_early: got %0h expected 0", alu_waiting); end
        step();
        n_checks++; if (alu_waiting !== 1'b1 || alu_vj !== 32'h22 || alu_vk !== 32'h33)
            begin n_fail++; $display("FAIL fwd_dispatch: got w=%0h vj=%0h vk=%0h expected w=1 vj=22 vk=33", alu_waiting, alu_vj, alu_vk); end
        step();
    endtask

    task automatic test_full();
        for (int i = 0; i < 8; i++) begin
            issue(6'd1, 32'd0, 1'b1, 4'd9, 32'(100 + i), 1'b0, 4'd0, 32'(i), 4'(8 + i));
            step();
        end
        idle();
        n_checks++; if (rs_full !== 1'b1) begin n_fail++; $display("FAIL full_set: got %0h expected 1", rs_full); end
        issue(6'd2, 32'hdead, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 4'd15);
        step();
        idle();
        n_checks++; if (rs_full !== 1'b1 || alu_waiting !== 1'b0)
            begin n_fail++; $display("FAIL full_ignore: got full=%0h w=%0h expected full=1 w=0", rs_full, alu_waiting); end
        lsb_cdb_valid = 1'b1; lsb_cdb_rob_id = 4'd9; lsb_cdb_value = 32'd3;
        step();
        idle();
        n_checks++; if (alu_waiting !== 1'b0) begin n_fail++; $display("FAIL full_wake_edge: got %0h expected 0", alu_waiting); end
        for (int k = 0; k < 8; k++) begin
            step();
            n_checks++; if (alu_waiting !== 1'b1 || alu_vj !== 32'd3 || alu_vk !== 32'(100 + k) || alu_imm !== 32'(k))
                begin n_fail++; $display("FAIL full_drain%0d: got w=%0h vj=%0h vk=%0d imm=%0d expected w=1 vj=3 vk=%0d imm=%0d", k, alu_waiting, alu_vj, alu_vk, alu_imm, 100 + k, k); end
            if (k == 0) begin
                n_checks++; if (rs_full !== 1'b0) begin n_fail++; $display("FAIL full_drop: got %0h expected 0", rs_full); end
            end else begin
                n_checks++; if (result_rob_id !== 4'(8 + k - 1)) begin n_fail++; $display("FAIL full_result%0d: got %0d expected %0d", k, result_rob_id, 8 + k - 1); end
            end
        end
        step();
        n_checks++; if (alu_waiting !== 1'b0 || result_rob_id !== 4'd15)
            begin n_fail++; $display("FAIL full_end: got w=%0h res=%0d expected w=0 res=15", alu_waiting, result_rob_id); end
        step();
    endtask

    task automatic test_clear();
        for (int i = 0; i < 5; i++) begin
            issue(6'd4, 32'(i), 1'b1, 4'd12, 32'd0, 1'b0, 4'd0, 32'd0, 4'(i + 1));
            step();
        end
        issue(6'd5, 32'h77, 1'b0, 4'd0, 32'h88, 1'b0, 4'd0, 32'd0, 4'd7);
        step();
        idle();
        step();
        n_checks++; if (alu_waiting !== 1'b1 || alu_vj !== 32'h77)
            begin n_fail++; $display("FAIL clear_pre: got w=%0h vj=%0h expected w=1 vj=77", alu_waiting, alu_vj); end
        rob_clear = 1'b1;
        issue(6'd6, 32'h55, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 4'd6);
        step();
        idle();
        n_checks++; if (alu_waiting !== 1'b0 || rs_full !== 1'b0 || result_rob_id !== 4'd0)
            begin n_fail++; $display("FAIL clear_state: got w=%0h full=%0h res=%0d expected w=0 full=0 res=0", alu_waiting, rs_full, result_rob_id); end
        alu_cdb_valid = 1'b1; alu_cdb_rob_id = 4'd12; alu_cdb_value = 32'h99;
        step();
        idle();
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (alu_waiting !== 1'b0) begin n_fail++; $display("FAIL clear_stale%0d: got %0h expected 0", i, alu_waiting); end
            step();
        end
    endtask

    task automatic test_rdy();
        issue(6'd6, 32'd1, 1'b1, 4'd13, 32'd2, 1'b0, 4'd0, 32'd0, 4'd3);
        step();
        issue(6'd7, 32'h44, 1'b0, 4'd0, 32'h45, 1'b0, 4'd0, 32'd0, 4'd4);
        step();
        idle();
        rdy_in = 1'b0;
        alu_cdb_valid = 1'b1; alu_cdb_rob_id = 4'd13; alu_cdb_value = 32'hab;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++; if (alu_waiting !== 1'b0) begin n_fail++; $display("FAIL rdy_frozen%0d: got %0h expected 0", i, alu_waiting); end
        end
        rdy_in = 1'b1;
        idle();
        step();
        n_checks++; if (alu_waiting !== 1'b1 || alu_vj !== 32'h44 || alu_op !== 6'd7)
            begin n_fail++; $display("FAIL rdy_resume: got w=%0h vj=%0h op=%0h expected w=1 vj=44 op=7", alu_waiting, alu_vj, alu_op); end
        step();
        n_checks++; if (alu_waiting !== 1'b0 || result_rob_id !== 4'd4)
            begin n_fail++; $display("FAIL rdy_lost_bcast: got w=%0h res=%0d expected w=0 res=4", alu_waiting, result_rob_id); end
        alu_cdb_valid = 1'b1; alu_cdb_rob_id = 4'd13; alu_cdb_value = 32'h5a;
        step();
        idle();
        n_checks++; if (alu_waiting !== 1'b0) begin n_fail++; $display("FAIL rdy_rewake_edge: got %0h expected 0", alu_waiting); end
        step();
        n_checks++; if (alu_waiting !== 1'b1 || alu_vj !== 32'h5a || alu_vk !== 32'd2)
            begin n_fail++; $display("FAIL rdy_rewake: got w=%0h vj=%0h vk=%0h expected w=1 vj=5a vk=2", alu_waiting, alu_vj, alu_vk); end
        step();
        step();
    endtask

    task automatic test_reset_midrun();
        for (int i = 0; i < 3; i++) begin
            issue(6'd3, 32'd0, 1'b1, 4'd14, 32'd0, 1'b0, 4'd0, 32'd0, 4'(i + 1));
            step();
        end
        issue(6'd3, 32'h66, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 4'd9);
        step();
        idle();
        step();
        n_checks++; if (alu_waiting !== 1'b1 || alu_vj !== 32'h66)
            begin n_fail++; $display("FAIL mrst_pre: got w=%0h vj=%0h expected w=1 vj=66", alu_waiting, alu_vj); end
        #2 rst_in = 1'b1;
        #1;
        n_checks++; if (alu_waiting !== 1'b0 || rs_full !== 1'b0 || alu_vj !== 32'h0)
            begin n_fail++; $display("FAIL mrst_async: got w=%0h full=%0h vj=%0h expected w=0 full=0 vj=0", alu_waiting, rs_full, alu_vj); end
        #1 rst_in = 1'b0;
        lsb_cdb_valid = 1'b1; lsb_cdb_rob_id = 4'd14; lsb_cdb_value = 32'd1;
        step();
        idle();
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (alu_waiting !== 1'b0) begin n_fail++; $display("FAIL mrst_after%0d: got %0h expected 0", i, alu_waiting); end
            step();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_wakeup();
        test_full();
        test_clear();
        test_rdy();
        test_reset_midrun();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_rs.md
Name: alu_rs

Overview:
- Reservation station for the integer ALU.
- Buffers decoded ALU/branch instructions from the issue stage and snoops the two CDB buses (ALU and LSB) to capture missing operands.
- Dispatches at most one ready instruction per cycle to the ALU (vj/vk/imm/op/waiting).
- Delays the destination RoB tag so it pairs with the ALU's registered result.
- Flushes on RoB clear.

Parameters:
RS_WIDTH, 3, log2 of entry count (RS_SIZE = 1<<RS_WIDTH = 8)
ROB_WIDTH, 4, RoB tag width

Ports:
clk_in  input  1  system clock
rst_in  input  1  reset; asynchronous, active-high
rdy_in  input  1  global enable; all state frozen when low
rob_clear  input  1  synchronous flush (misprediction)
issue_valid  input  1  new instruction this cycle
issue_op  input  6  ALU opcode, passed through unchanged
issue_vj  input  32  operand j value (meaningful when issue_qj_busy=0)
issue_qj_busy  input  1  operand j pending
issue_qj  input  ROB_WIDTH  RoB tag producing operand j
issue_vk  input  32  operand k value
issue_qk_busy  input  1  operand k pending
issue_qk  input  ROB_WIDTH  RoB tag producing operand k
issue_imm  input  32  immediate
issue_rob_id  input  ROB_WIDTH  destination RoB tag
alu_cdb_valid  input  1  ALU result broadcast valid
alu_cdb_rob_id  input  ROB_WIDTH  ALU broadcast tag
alu_cdb_value  input  32  ALU broadcast value
lsb_cdb_valid  input  1  load result broadcast valid
lsb_cdb_rob_id  input  ROB_WIDTH  LSB broadcast tag
lsb_cdb_value  input  32  LSB broadcast value
rs_full  output  1  all entries busy
alu_waiting  output  1  dispatch strobe to ALU (registered)
alu_vj  output  32  dispatched operand j (registered)
alu_vk  output  32  dispatched operand k (registered)
alu_imm  output  32  dispatched immediate (registered)
alu_op  output  6  dispatched opcode (registered)
result_rob_id  output  ROB_WIDTH  destination tag aligned with ALU result (one cycle after alu_waiting)

Behaviour:
- Reset (async, rst_in=1): all entries not busy; alu_waiting=0; alu_vj/vk/imm=0; alu_op=0; result_rob_id=0.
- rdy_in=0: no state changes, outputs held.
- rob_clear=1 (when rdy_in=1): all entries not busy; alu_waiting=0; result_rob_id=0; issue ignored that cycle.
- Entry fields: busy, op, vj, qj_busy, qj, vk, qk_busy, qk, imm, rob_id.
- rs_full: combinational, 1 iff all RS_SIZE entries busy at cycle start. A slot freed by this cycle's dispatch is not reusable until next cycle.
- Issue: if issue_valid && !rs_full, write the lowest-index free entry.
  - issue_valid while rs_full: ignored (issuer protocol violation, no corruption).
- Issue-time forwarding: if issue_qj_busy and a valid CDB tag equals issue_qj in the same cycle, store that value with qj_busy=0. Same for k.
- Wakeup: each cycle, every busy entry with qX_busy and a matching valid CDB tag captures the value and clears qX_busy.
  - If both buses match the same tag, the ALU bus wins (cannot occur legally).
- Ready: busy && !qj_busy && !qk_busy, evaluated on registered state at cycle start. Wakeup-to-dispatch and issue-to-dispatch are therefore ≥1 cycle.
- Dispatch: if any entry is ready, select the lowest index.
  - Next edge: alu_waiting=1; alu_vj/vk/imm/op = entry fields; entry freed.
  - Otherwise alu_waiting=0 and data outputs are zeroed.
- Latency: dispatch edge t drives ALU inputs; ALU result registered at t+1.
  - result_rob_id is loaded at t+1 with the tag dispatched at t, so it is valid alongside ALU_finish_rdy.
  - result_rob_id = 0 when no dispatch occurred at t.
- Throughput: one dispatch per cycle, sustained.
- Issue, wakeup and dispatch may touch different entries in the same cycle; all are applied.

Test Plan:
- Reset mid-run with 3 busy entries, rst_in pulsed asynchronously between edges -> immediately alu_waiting=0, rs_full=0; after release no dispatch occurs.
- Issue op=6'b000011 (add) with vj=5, vk=7, no pending, rob_id=2 at cycle 0 -> cycle 1: alu_waiting=1, vj=5, vk=7; cycle 2: result_rob_id=2.
- Issue with qj_busy, qj=4; alu_cdb_valid tag=4 value=0x10 two cycles later -> dispatch exactly one cycle after the broadcast with vj=0x10. Same-cycle broadcast at issue -> dispatch on the next cycle.
- Fill 8 entries, all blocked on tag 9 -> rs_full=1; extra issue ignored. lsb_cdb tag=9 value=3 -> entries dispatch in index order 0..7 on 8 consecutive cycles, each vj=3; rs_full drops the cycle after the first dispatch.
- rob_clear with 5 busy entries and alu_waiting=1 -> next cycle alu_waiting=0, rs_full=0, result_rob_id=0; later CDB for an old tag dispatches nothing.
- rdy_in held low for 3 cycles with a ready entry and an active CDB broadcast -> no dispatch and no wakeup; the broadcast is lost and the entry remains pending after rdy_in returns.
